// File: rtl/seg7_pkg.sv
// Shared constants and hex-to-segment decode for the 7-segment scan driver.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Active-low g..a patterns, entry 15 first.
  localparam logic [15:0][6:0] HEX_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_seg(
    input logic [3:0] nib
  );
    return HEX_LUT[nib];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display word in from the multiplexer, scanned anode/segment lines out.
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  logic        en;
  logic [31:0] disp_num;
  logic [7:0]  point_in;
  logic [7:0]  le_in;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  modport master (
    output en,
    output disp_num,
    output point_in,
    output le_in,
    input  an,
    input  seg,
    input  frame_done
  );

  modport slave (
    input  en,
    input  disp_num,
    input  point_in,
    input  le_in,
    output an,
    output seg,
    output frame_done
  );

endinterface

// File: rtl/hex7seg.sv
// Combinational nibble + decimal point to active-low segment byte.
module hex7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {~dp, hex_seg(nib)};

endmodule

// File: rtl/seg7_scan_driver.sv
// 8-digit common-anode scan driver with per-frame input capture and blink.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIV_BITS   = 16,
  parameter int BLINK_BITS = 6
) (
  input  logic clk,
  input  logic rst,
  seg7_scan_driver_if.slave bus
);

  logic [DIV_BITS-1:0]   cnt;
  logic [2:0]            idx;
  logic [2:0]            nxt;
  logic [BLINK_BITS-1:0] blink;
  logic [BLINK_BITS-1:0] blink_nxt;

  logic [31:0] shadow_num;
  logic [7:0]  shadow_pt;
  logic [7:0]  shadow_le;

  logic [31:0] num_sel;
  logic [7:0]  pt_sel;
  logic [7:0]  le_sel;
  logic [3:0]  nib;
  logic [7:0]  seg_dec;
  logic        tick;
  logic        wrap;
  logic        blank;

  logic [7:0]  an_q;
  logic [7:0]  seg_q;
  logic        fd_q;

  assign tick      = bus.en && (cnt == {DIV_BITS{1'b1}});
  assign wrap      = (idx == 3'd7);
  assign nxt       = idx + 3'd1;
  assign blink_nxt = blink + 1'b1;

  // Digit 0 shows the word being captured on this same edge.
  assign num_sel = wrap ? bus.disp_num : shadow_num;
  assign pt_sel  = wrap ? bus.point_in : shadow_pt;
  assign le_sel  = wrap ? bus.le_in    : shadow_le;

  assign nib   = num_sel[{nxt, 2'b00} +: 4];
  assign blank = le_sel[nxt] && blink_nxt[BLINK_BITS-1];

  hex7seg u_hex (
    .nib (nib),
    .dp  (pt_sel[nxt]),
    .seg (seg_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 3'd7;
      blink      <= '0;
      shadow_num <= '0;
      shadow_pt  <= '0;
      shadow_le  <= '0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_BLANK;
      fd_q       <= 1'b0;
    end else if (!bus.en) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
      fd_q  <= 1'b0;
    end else begin
      cnt  <= cnt + 1'b1;
      fd_q <= 1'b0;
      if (tick) begin
        idx   <= nxt;
        blink <= blink_nxt;
        an_q  <= ~(8'd1 << nxt);
        seg_q <= blank ? SEG_BLANK : seg_dec;
        if (wrap) begin
          shadow_num <= bus.disp_num;
          shadow_pt  <= bus.point_in;
          shadow_le  <= bus.le_in;
          fd_q       <= 1'b1;
        end
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: reference model queues per-cycle expectations, monitor checks.
module tb_seg7_scan_driver;

  localparam int PER   = 4;
  localparam int BLINK = 4;

  logic clk = 1'b0;
  logic rst;

  seg7_scan_driver_if bus_i ();

  seg7_scan_driver #(
    .DIV_BITS   (2),
    .BLINK_BITS (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
    logic       fd;
  } exp_t;

  exp_t q[$];

  int vectors = 0;
  int errors  = 0;

  logic [6:0] lut [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  int         en_cycles = 0;
  int         ticks     = 0;
  logic [31:0] f_num = '0;
  logic [7:0]  f_pt  = '0;
  logic [7:0]  f_le  = '0;
  logic [7:0]  m_an  = 8'hFF;
  logic [7:0]  m_seg = 8'hFF;
  logic        m_fd  = 1'b0;

  // Model: count enabled clocks; every PER-th is a digit step.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        en_cycles = 0;
        ticks     = 0;
        f_num     = '0;
        f_pt      = '0;
        f_le      = '0;
        m_an      = 8'hFF;
        m_seg     = 8'hFF;
        m_fd      = 1'b0;
        q.delete();
      end else if (!bus_i.en) begin
        m_an  = 8'hFF;
        m_seg = 8'hFF;
        m_fd  = 1'b0;
      end else begin
        m_fd = 1'b0;
        en_cycles++;
        if (en_cycles % PER == 0) begin
          int d;
          logic [3:0] n;
          ticks++;
          d = (ticks + 7) % 8;
          if (d == 0) begin
            f_num = bus_i.disp_num;
            f_pt  = bus_i.point_in;
            f_le  = bus_i.le_in;
            m_fd  = 1'b1;
          end
          n     = 4'((f_num >> (4 * d)) & 32'hF);
          m_an  = ~(8'd1 << d);
          m_seg = {~f_pt[d], lut[n]};
          if (f_le[d] && (ticks % BLINK) >= BLINK / 2)
            m_seg = 8'hFF;
        end
      end
      q.push_back('{m_an, m_seg, m_fd});
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        vectors++;
        if (bus_i.an !== e.an || bus_i.seg !== e.seg
            || bus_i.frame_done !== e.fd) begin
          errors++;
          $display("FAIL scan @%0t: an=%h seg=%h fd=%b, want an=%h seg=%h fd=%b",
                   $time, bus_i.an, bus_i.seg, bus_i.frame_done,
                   e.an, e.seg, e.fd);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic async_reset_check();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus_i.an !== 8'hFF || bus_i.seg !== 8'hFF
        || bus_i.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: an=%h seg=%h fd=%b, want an=ff seg=ff fd=0",
               bus_i.an, bus_i.seg, bus_i.frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    bus_i.en         = 1'b0;
    bus_i.disp_num   = '0;
    bus_i.point_in   = '0;
    bus_i.le_in      = '0;
    step(3);
    rst              = 1'b0;
    bus_i.en         = 1'b1;
    bus_i.disp_num   = 32'h12345678;
    step(40);
    bus_i.point_in   = 8'h01;
    step(36);
    bus_i.point_in   = 8'h00;
    // Change the word mid-frame; it must not appear until digit 0.
    step(13);
    bus_i.disp_num   = 32'hFFFFFFFF;
    step(30);
    bus_i.disp_num   = 32'h12345678;
    bus_i.le_in      = 8'h02;
    step(140);
    bus_i.le_in      = 8'h00;
    step(6);
    bus_i.en         = 1'b0;
    step(9);
    bus_i.en         = 1'b1;
    step(20);
    async_reset_check();
    step(10);
    for (int i = 0; i < 60; i++) begin
      bus_i.disp_num = $urandom;
      bus_i.point_in = 8'($urandom);
      bus_i.le_in    = 8'($urandom);
      bus_i.en       = ($urandom_range(0, 7) != 0);
      step($urandom_range(1, 40));
      if (i == 30) async_reset_check();
    end
    bus_i.en = 1'b1;
    step(40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
